// File: rtl/char_line_buffer.sv
// Character store for the plotter input path: edge-triggered capture into a
// DEPTH-entry array with fill/overflow/EOF tracking and a registered read port.
module char_line_buffer #(
  parameter int CHAR_W = 6,
  parameter int DEPTH  = 100,
  parameter int IDX_W  = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CHAR_W-1:0] next_char,
  input  logic              char_ready,
  input  logic              eof,
  input  logic              clear,
  input  logic [IDX_W-1:0]  rd_sel,
  output logic [CHAR_W-1:0] rd_char,
  output logic              rd_valid,
  output logic [IDX_W-1:0]  count,
  output logic              full,
  output logic              overflow,
  output logic              done,
  output logic [7:0]        debug
);

  localparam logic [IDX_W-1:0] DEPTH_I  = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0] DEPTH_M1 = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_FULL, S_DONE} state_t;

  state_t            state, state_nxt;
  logic              cr_q, eof_q;
  logic              wr_ev, eof_ev;
  logic              do_write, set_ovf;
  logic [CHAR_W-1:0] mem [DEPTH];

  assign wr_ev  = char_ready & ~cr_q;
  assign eof_ev = eof & ~eof_q;
  assign debug  = {eof, char_ready, next_char[5:0]};

  // Edge detectors reset high so a level held through reset release is ignored
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cr_q  <= 1'b1;
      eof_q <= 1'b1;
    end else begin
      cr_q  <= char_ready;
      eof_q <= eof;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY:   if (eof_ev) state_nxt = S_DONE;
                   else if (wr_ev) state_nxt = S_FILLING;
        S_FILLING: if (eof_ev) state_nxt = S_DONE;
                   else if (wr_ev && count == DEPTH_M1) state_nxt = S_FULL;
        S_FULL:    if (eof_ev) state_nxt = S_DONE;
        default:   state_nxt = S_DONE;
      endcase
    end
  end

  always_comb begin
    do_write = 1'b0;
    set_ovf  = 1'b0;
    if (!clear && wr_ev) begin
      do_write = (state == S_EMPTY) || (state == S_FILLING);
      set_ovf  = (state == S_FULL);
    end
    done = (state == S_DONE);
    full = (state == S_FULL) || ((state == S_DONE) && (count == DEPTH_I));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) count <= count + 1'b1;
      if (set_ovf)  overflow <= 1'b1;
    end
  end

  // Storage is never reset; stale entries are hidden by the count range check
  always_ff @(posedge clock) begin
    if (do_write) mem[count] <= next_char;
  end

  // Read stage: one cycle after rd_sel
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_char  <= '0;
      rd_valid <= 1'b0;
    end else if (rd_sel < count) begin
      rd_char  <= mem[rd_sel];
      rd_valid <= 1'b1;
    end else begin
      rd_char  <= '0;
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_char_line_buffer.sv
// Directed-vector bench for char_line_buffer.
module tb_char_line_buffer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] next_char = '0;
  logic       char_ready = 1'b0;
  logic       eof = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] rd_sel = '0;
  logic [5:0] rd_char;
  logic       rd_valid;
  logic [6:0] count;
  logic       full, overflow, done;
  logic [7:0] debug;

  int vectors = 0;
  int errors  = 0;

  char_line_buffer #(.CHAR_W(6), .DEPTH(100), .IDX_W(7)) dut (
    .clock(clock), .reset(reset), .next_char(next_char), .char_ready(char_ready),
    .eof(eof), .clear(clear), .rd_sel(rd_sel), .rd_char(rd_char),
    .rd_valid(rd_valid), .count(count), .full(full), .overflow(overflow),
    .done(done), .debug(debug)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic write_char(input logic [5:0] d);
    next_char  = d;
    char_ready = 1'b1;
    tick();
    char_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    char_ready = 1'b0; eof = 1'b0; clear = 1'b0; rd_sel = '0;
    do_reset();
    vectors++; if (count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    vectors++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (rd_valid !== 1'b0 || rd_char !== 6'h00) begin errors++; $display("FAIL reset_rd: got %b/%h want 0/00", rd_valid, rd_char); end
  endtask

  task automatic test_basic();
    do_reset();
    write_char(6'h0A);
    write_char(6'h15);
    write_char(6'h3F);
    vectors++; if (count !== 7'd3) begin errors++; $display("FAIL basic_count: got %0d want 3", count); end
    vectors++; if (full !== 1'b0) begin errors++; $display("FAIL basic_full: got %b want 0", full); end
    rd_sel = 7'd1;
    tick();
    vectors++; if (rd_char !== 6'h15 || rd_valid !== 1'b1) begin errors++; $display("FAIL basic_rd1: got %h/%b want 15/1", rd_char, rd_valid); end
    rd_sel = 7'd2;
    tick();
    vectors++; if (rd_char !== 6'h3F || rd_valid !== 1'b1) begin errors++; $display("FAIL basic_rd2: got %h/%b want 3f/1", rd_char, rd_valid); end
    rd_sel = 7'd3;
    tick();
    vectors++; if (rd_char !== 6'h00 || rd_valid !== 1'b0) begin errors++; $display("FAIL basic_rd3: got %h/%b want 00/0", rd_char, rd_valid); end
  endtask

  task automatic test_hold();
    do_reset();
    next_char  = 6'h05;
    char_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    vectors++; if (count !== 7'd1) begin errors++; $display("FAIL hold_count: got %0d want 1", count); end
    // level held high across reset release
    do_reset();
    tick(); tick(); tick();
    vectors++; if (count !== 7'd0) begin errors++; $display("FAIL hold_reset_count: got %0d want 0", count); end
    char_ready = 1'b0;
    tick();
    char_ready = 1'b1;
    tick();
    vectors++; if (count !== 7'd1) begin errors++; $display("FAIL hold_rearm_count: got %0d want 1", count); end
    char_ready = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 100; i++) write_char(6'(i % 64));
    vectors++; if (count !== 7'd100) begin errors++; $display("FAIL ovf_count_full: got %0d want 100", count); end
    vectors++; if (full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_full_flags: got full=%b ovf=%b want 1/0", full, overflow); end
    write_char(6'h11);
    vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    vectors++; if (count !== 7'd100 || full !== 1'b1) begin errors++; $display("FAIL ovf_count_hold: got %0d/%b want 100/1", count, full); end
    rd_sel = 7'd99;
    tick();
    vectors++; if (rd_char !== 6'd35 || rd_valid !== 1'b1) begin errors++; $display("FAIL ovf_rd99: got %0d/%b want 35/1", rd_char, rd_valid); end
    rd_sel = 7'd100;
    tick();
    vectors++; if (rd_valid !== 1'b0 || rd_char !== 6'h00) begin errors++; $display("FAIL ovf_rd100: got %h/%b want 00/0", rd_char, rd_valid); end
  endtask

  task automatic test_eof();
    do_reset();
    write_char(6'h01);
    next_char  = 6'h02;
    char_ready = 1'b1;
    eof        = 1'b1;
    tick();
    vectors++; if (count !== 7'd2 || done !== 1'b1) begin errors++; $display("FAIL eof_same_cycle: got count=%0d done=%b want 2/1", count, done); end
    char_ready = 1'b0;
    tick();
    write_char(6'h03);
    vectors++; if (count !== 7'd2 || done !== 1'b1) begin errors++; $display("FAIL eof_frozen: got count=%0d done=%b want 2/1", count, done); end
    rd_sel = 7'd1;
    tick();
    vectors++; if (rd_char !== 6'h02 || rd_valid !== 1'b1) begin errors++; $display("FAIL eof_rd1: got %h/%b want 02/1", rd_char, rd_valid); end
    vectors++; if (full !== 1'b0) begin errors++; $display("FAIL eof_full: got %b want 0", full); end
    eof = 1'b0;
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 101; i++) write_char(6'(i % 64));
    eof = 1'b1;
    tick();
    vectors++; if (done !== 1'b1 || full !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL clr_pre: got done=%b full=%b ovf=%b want 1/1/1", done, full, overflow); end
    clear      = 1'b1;
    next_char  = 6'h2B;
    char_ready = 1'b1;
    tick();
    clear = 1'b0;
    vectors++; if (count !== 7'd0 || done !== 1'b0 || overflow !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL clr_status: got count=%0d done=%b ovf=%b full=%b want 0/0/0/0", count, done, overflow, full); end
    rd_sel = 7'd0;
    tick();
    vectors++; if (rd_valid !== 1'b0 || rd_char !== 6'h00 || count !== 7'd0) begin errors++; $display("FAIL clr_rd0: got %h/%b count=%0d want 00/0/0", rd_char, rd_valid, count); end
    char_ready = 1'b0;
    tick();
    write_char(6'h2C);
    tick();
    vectors++; if (rd_char !== 6'h2C || rd_valid !== 1'b1 || count !== 7'd1 || done !== 1'b0) begin errors++; $display("FAIL clr_next_write: got %h/%b count=%0d done=%b want 2c/1/1/0", rd_char, rd_valid, count, done); end
    eof = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) write_char(6'(6'h30 + i));
    rd_sel = 7'd2;
    tick();
    vectors++; if (count !== 7'd5 || rd_char !== 6'h32 || rd_valid !== 1'b1) begin errors++; $display("FAIL arst_pre: got count=%0d rd=%h/%b want 5/32/1", count, rd_char, rd_valid); end
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (count !== 7'd0 || rd_char !== 6'h00 || rd_valid !== 1'b0) begin errors++; $display("FAIL arst_now: got count=%0d rd=%h/%b want 0/00/0", count, rd_char, rd_valid); end
    vectors++; if (full !== 1'b0 || overflow !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL arst_flags: got full=%b ovf=%b done=%b want 0/0/0", full, overflow, done); end
    next_char  = 6'h15;
    char_ready = 1'b1;
    eof        = 1'b1;
    #1;
    vectors++; if (debug !== 8'hD5) begin errors++; $display("FAIL debug_hi: got %h want d5", debug); end
    next_char  = 6'h2A;
    char_ready = 1'b0;
    eof        = 1'b0;
    #1;
    vectors++; if (debug !== 8'h2A) begin errors++; $display("FAIL debug_lo: got %h want 2a", debug); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_overflow();
    test_eof();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
